mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM stage plus MEM/WB pipeline register; consumes EX/MEM register outputs.
//  Performs data-memory load/store with programmable wait states, stalls upstream while busy.
//  Registers load data, ALU result, PC+4 and WB control toward the write-back mux / register file.
// PARAMETERS
//  BIT_WIDTH    32            datapath width
//  DEPTH        256           data memory words (power of 2)
//  WAIT_CYCLES  0             extra cycles per load/store (0 = single-cycle access)
//  DATA_BASE    32'h1001_0000 byte address mapped to word 0
// PORTS
//  clk                   in   1   clock; all state updates on falling edge (pipeline is negedge)
//  rst                   in   1   synchronous, active-high reset
//  ALUResult_EXMEM       in   32  effective address / ALU result
//  reg_2ALUB_EXMEM       in   32  store data
//  mux_regWriteA3_EXMEM  in   32  destination register index
//  Addresult_4_EXMEM     in   32  PC+4 (link value)
//  PC_instruction_EXMEM  in   32  instruction PC (debug trace)
//  RegWrite_EXMEM, MemWrite_EXMEM, MemtoReg_EXMEM  in 1  control; MemtoReg=1 marks a load
//  RegDst_EXMEM          in   2   WB select
//  stall_MEM             out  1   hold EX/MEM and earlier stages
//  ReadData_MEMWB, ALUResult_MEMWB, mux_regWriteA3_MEMWB, Addresult_4_MEMWB, PC_instruction_MEMWB  out 32
//  RegWrite_MEMWB, MemtoReg_MEMWB  out 1;  RegDst_MEMWB  out 2
//  misalign_MEMWB        out  1   alignment fault flag (see CONFIGURATION)
// BEHAVIOUR
//  - access = MemWrite_EXMEM | MemtoReg_EXMEM.
//  - index = ((ALUResult_EXMEM - DATA_BASE) >> 2) mod DEPTH; out-of-range addresses wrap, never fault.
//  - Reset: every MEM/WB output 0, stall_MEM 0, FSM MEM_IDLE, cnt 0; RAM contents untouched.
//  - WAIT_CYCLES==0: no FSM activity; each edge commits store (if MemWrite) and registers inputs;
//    ReadData_MEMWB <= mem[index] when MemtoReg, else 0. Latency 1 edge.
//  - WAIT_CYCLES>0 FSM {MEM_IDLE, MEM_BUSY}, counter cnt:
//    MEM_IDLE & access -> MEM_BUSY, cnt <= WAIT_CYCLES-1.
//    MEM_BUSY & cnt!=0 -> cnt <= cnt-1.
//    MEM_BUSY & cnt==0 -> commit access, load MEM/WB with real values, -> MEM_IDLE.
//    stall_MEM (combinational) = access & !(state==MEM_BUSY & cnt==0); high for exactly WAIT_CYCLES edges.
//    Non-access instructions pass in 1 edge with no stall.
//  - While stall_MEM=1 the MEM/WB register loads a bubble (all outputs 0, RegWrite_MEMWB=0).
//  - Store commits exactly once, on the completion edge; never during wait cycles.
//  - Inputs must stay stable while stall_MEM=1 (upstream guarantee); no internal capture.
//  - Load reads array value before same-edge write (one access per instruction, no conflict).
//  - Reset mid-access: FSM to MEM_IDLE, pending store discarded, no partial write.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: access with ALUResult_EXMEM[1:0]!=0 -> store suppressed,
//    ReadData_MEMWB=0, RegWrite_MEMWB=0, misalign_MEMWB=1 for that instruction
//    (still waits WAIT_CYCLES).
//  Not defined: low address bits ignored, misalign_MEMWB tied 0.
// STRUCTURE
//  Package mips_pipe_pkg: typedef enum logic {MEM_IDLE, MEM_BUSY} mem_state_t;
//    DATA_BASE default, BIT_WIDTH constant.
//  Sub-module data_mem: DEPTH x BIT_WIDTH array, negedge synchronous write, asynchronous read.
//  Top holds FSM, counter, stall logic and MEM/WB register.
// TESTING
//  1 WAIT=0: store 0xDEADBEEF @0x10010004, then load 0x10010004 -> ReadData_MEMWB=0xDEADBEEF next edge, stall_MEM never 1.
//  2 WAIT=2: load -> stall_MEM high 2 edges, bubbles (RegWrite_MEMWB=0) on those edges, data on 3rd edge.
//  3 WAIT=2: store 0x12345678, read RAM after each edge -> unchanged until completion edge, then written once.
//  4 rst=1 during MEM_BUSY store -> next edge outputs 0, stall_MEM 0, RAM word keeps old value.
//  5 Address DATA_BASE + DEPTH*4 -> aliases word 0; ALU op (no access) -> ALUResult_MEMWB follows in 1 edge, no stall.
//  6 MEM_ALIGN_CHECK_EN: store @0x10010002 -> RAM unchanged, misalign_MEMWB=1, RegWrite_MEMWB=0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared types and constants for the MEM/WB pipeline slice
package mips_pipe_pkg;
    typedef enum logic {MEM_IDLE, MEM_BUSY} mem_state_t;
    localparam int PIPE_WIDTH = 32;
    localparam logic [31:0] DATA_BASE_DEFAULT = 32'h1001_0000;
endpackage

// File: rtl/data_mem.sv
// data_mem: word-addressed data RAM, falling-edge synchronous write, asynchronous read
module data_mem #(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_addr,
    input  logic [BIT_WIDTH-1:0] i_wdata,
    output logic [BIT_WIDTH-1:0] o_rdata
);
    logic [BIT_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(negedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage with wait-state FSM and MEM/WB register (negedge pipeline)
// Optional alignment fault checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_wb_stage import mips_pipe_pkg::*; #(
    parameter int BIT_WIDTH = PIPE_WIDTH,
    parameter int DEPTH = 256,
    parameter int WAIT_CYCLES = 0,
    parameter logic [BIT_WIDTH-1:0] DATA_BASE = DATA_BASE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] ALUResult_EXMEM,
    input  logic [BIT_WIDTH-1:0] reg_2ALUB_EXMEM,
    input  logic [BIT_WIDTH-1:0] mux_regWriteA3_EXMEM,
    input  logic [BIT_WIDTH-1:0] Addresult_4_EXMEM,
    input  logic [BIT_WIDTH-1:0] PC_instruction_EXMEM,
    input  logic                 RegWrite_EXMEM,
    input  logic                 MemWrite_EXMEM,
    input  logic                 MemtoReg_EXMEM,
    input  logic [1:0]           RegDst_EXMEM,
    output logic                 stall_MEM,
    output logic [BIT_WIDTH-1:0] ReadData_MEMWB,
    output logic [BIT_WIDTH-1:0] ALUResult_MEMWB,
    output logic [BIT_WIDTH-1:0] mux_regWriteA3_MEMWB,
    output logic [BIT_WIDTH-1:0] Addresult_4_MEMWB,
    output logic [BIT_WIDTH-1:0] PC_instruction_MEMWB,
    output logic                 RegWrite_MEMWB,
    output logic                 MemtoReg_MEMWB,
    output logic [1:0]           RegDst_MEMWB,
    output logic                 misalign_MEMWB
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    mem_state_t r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic w_access, w_stall, w_misalign, w_we;
    logic [AW-1:0] w_index;
    logic [BIT_WIDTH-1:0] w_rdata;

    assign w_access = MemWrite_EXMEM | MemtoReg_EXMEM;
    // Addresses outside the window simply wrap onto the array.
    assign w_index = AW'((ALUResult_EXMEM - DATA_BASE) >> 2);
`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_access & (|ALUResult_EXMEM[1:0]);
`else
    assign w_misalign = 1'b0;
`endif
    assign w_stall = (WAIT_CYCLES != 0) && w_access && !(r_state == MEM_BUSY && r_cnt == '0);
    assign stall_MEM = w_stall;
    // Reset drops any store that would otherwise complete on this edge.
    assign w_we = MemWrite_EXMEM && !w_stall && !w_misalign && !rst;

    data_mem #(.BIT_WIDTH(BIT_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk    (clk),
        .i_we   (w_we),
        .i_addr (w_index),
        .i_wdata(reg_2ALUB_EXMEM),
        .o_rdata(w_rdata)
    );

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx = r_cnt;
        if (WAIT_CYCLES != 0) begin
            if (r_state == MEM_IDLE && w_access) begin
                w_state_nx = MEM_BUSY;
                w_cnt_nx = CNT_INIT;
            end else if (r_state == MEM_BUSY) begin
                w_state_nx = (r_cnt == '0) ? MEM_IDLE : MEM_BUSY;
                w_cnt_nx = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
            end
        end
    end

    always_ff @(negedge clk) begin
        r_state <= rst ? MEM_IDLE : w_state_nx;
        r_cnt <= rst ? '0 : w_cnt_nx;
        if (rst || w_stall) begin
            ReadData_MEMWB <= '0;
            ALUResult_MEMWB <= '0;
            mux_regWriteA3_MEMWB <= '0;
            Addresult_4_MEMWB <= '0;
            PC_instruction_MEMWB <= '0;
            RegWrite_MEMWB <= 1'b0;
            MemtoReg_MEMWB <= 1'b0;
            RegDst_MEMWB <= 2'b00;
            misalign_MEMWB <= 1'b0;
        end else begin
            ReadData_MEMWB <= (MemtoReg_EXMEM && !w_misalign) ? w_rdata : '0;
            ALUResult_MEMWB <= ALUResult_EXMEM;
            mux_regWriteA3_MEMWB <= mux_regWriteA3_EXMEM;
            Addresult_4_MEMWB <= Addresult_4_EXMEM;
            PC_instruction_MEMWB <= PC_instruction_EXMEM;
            RegWrite_MEMWB <= RegWrite_EXMEM && !w_misalign;
            MemtoReg_MEMWB <= MemtoReg_EXMEM;
            RegDst_MEMWB <= RegDst_EXMEM;
            misalign_MEMWB <= w_misalign;
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: self-checking bench driving a zero-wait and a two-wait instance
module tb_mem_wb_stage;
    localparam logic [31:0] BASE = 32'h1001_0000;

    typedef struct packed {
        logic [31:0] alu, wd, a3, pc4, pc;
        logic rw, mw, m2r;
        logic [1:0] rdst;
    } in_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t in0 = '0;
    in_t in1 = '0;
    int passed = 0;
    int total = 0;
    logic [31:0] mdl [2][256];
    bit kn [2][256];

    logic [31:0] rd0, al0, a30, p40, pc0, rd1, al1, a31, p41, pc1;
    logic rw0, mr0, mis0, st0, rw1, mr1, mis1, st1;
    logic [1:0] rs0, rs1;
    logic [164:0] obs0, obs1;
    assign obs0 = {rd0, al0, a30, p40, pc0, rw0, mr0, rs0, mis0};
    assign obs1 = {rd1, al1, a31, p41, pc1, rw1, mr1, rs1, mis1};

    always #5 clk = ~clk;

    mem_wb_stage #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst),
        .ALUResult_EXMEM(in0.alu), .reg_2ALUB_EXMEM(in0.wd), .mux_regWriteA3_EXMEM(in0.a3),
        .Addresult_4_EXMEM(in0.pc4), .PC_instruction_EXMEM(in0.pc),
        .RegWrite_EXMEM(in0.rw), .MemWrite_EXMEM(in0.mw), .MemtoReg_EXMEM(in0.m2r), .RegDst_EXMEM(in0.rdst),
        .stall_MEM(st0), .ReadData_MEMWB(rd0), .ALUResult_MEMWB(al0), .mux_regWriteA3_MEMWB(a30),
        .Addresult_4_MEMWB(p40), .PC_instruction_MEMWB(pc0), .RegWrite_MEMWB(rw0),
        .MemtoReg_MEMWB(mr0), .RegDst_MEMWB(rs0), .misalign_MEMWB(mis0)
    );

    mem_wb_stage #(.WAIT_CYCLES(2)) u_w1 (
        .clk(clk), .rst(rst),
        .ALUResult_EXMEM(in1.alu), .reg_2ALUB_EXMEM(in1.wd), .mux_regWriteA3_EXMEM(in1.a3),
        .Addresult_4_EXMEM(in1.pc4), .PC_instruction_EXMEM(in1.pc),
        .RegWrite_EXMEM(in1.rw), .MemWrite_EXMEM(in1.mw), .MemtoReg_EXMEM(in1.m2r), .RegDst_EXMEM(in1.rdst),
        .stall_MEM(st1), .ReadData_MEMWB(rd1), .ALUResult_MEMWB(al1), .mux_regWriteA3_MEMWB(a31),
        .Addresult_4_MEMWB(p41), .PC_instruction_MEMWB(pc1), .RegWrite_MEMWB(rw1),
        .MemtoReg_MEMWB(mr1), .RegDst_MEMWB(rs1), .misalign_MEMWB(mis1)
    );

    function automatic int idx(logic [31:0] a);
        return int'(((a - BASE) / 4) % 256);
    endfunction

    function automatic logic [164:0] expv(in_t x, logic [31:0] rd, logic mis);
        return {rd, x.alu, x.a3, x.pc4, x.pc, x.rw & ~mis, x.m2r, x.rdst, mis};
    endfunction

    function automatic logic [31:0] ram(int w, int i);
        return w != 0 ? u_w1.u_mem.r_mem[i] : u_w0.u_mem.r_mem[i];
    endfunction

    function automatic in_t mk(logic [31:0] alu, logic [31:0] wd, logic mw, logic m2r);
        in_t x;
        x.alu = alu;
        x.wd = wd;
        x.a3 = 32'($urandom_range(0, 31));
        x.pc4 = $urandom;
        x.pc = $urandom;
        x.rw = 1'($urandom_range(0, 1));
        x.mw = mw;
        x.m2r = m2r;
        x.rdst = 2'($urandom_range(0, 3));
        return x;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        in0 = '0;
        in1 = '0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (obs0 !== '0) $display("FAIL reset_out_w0 got %h exp 0", obs0); else passed++;
        total++; if (obs1 !== '0) $display("FAIL reset_out_w2 got %h exp 0", obs1); else passed++;
        total++; if (st0 !== 1'b0) $display("FAIL reset_stall_w0 got %b exp 0", st0); else passed++;
        total++; if (st1 !== 1'b0) $display("FAIL reset_stall_w2 got %b exp 0", st1); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_wait0;
        in_t x;
        x = mk(32'h1001_0004, 32'hDEAD_BEEF, 1'b1, 1'b0);
        in0 = x;
        #1;
        total++; if (st0 !== 1'b0) $display("FAIL w0_store_stall got %b exp 0", st0); else passed++;
        @(negedge clk); #1;
        total++; if (obs0 !== expv(x, 32'h0, 1'b0)) $display("FAIL w0_store_out got %h exp %h", obs0, expv(x, 32'h0, 1'b0)); else passed++;
        total++; if (ram(0, 1) !== 32'hDEAD_BEEF) $display("FAIL w0_store_ram got %h exp deadbeef", ram(0, 1)); else passed++;
        mdl[0][1] = 32'hDEAD_BEEF; kn[0][1] = 1'b1;
        x = mk(32'h1001_0004, $urandom, 1'b0, 1'b1);
        in0 = x;
        #1;
        total++; if (st0 !== 1'b0) $display("FAIL w0_load_stall got %b exp 0", st0); else passed++;
        @(negedge clk); #1;
        total++; if (obs0 !== expv(x, 32'hDEAD_BEEF, 1'b0)) $display("FAIL w0_load_out got %h exp %h", obs0, expv(x, 32'hDEAD_BEEF, 1'b0)); else passed++;
        in0 = '0;
    endtask

    task automatic test_wait_store;
        in_t x;
        x = mk(32'h1001_0008, 32'hA5A5_0001, 1'b1, 1'b0);
        in1 = x;
        repeat (3) @(negedge clk);
        #1;
        total++; if (ram(1, 2) !== 32'hA5A5_0001) $display("FAIL w2_prestore_ram got %h exp a5a50001", ram(1, 2)); else passed++;
        x = mk(32'h1001_0008, 32'h1234_5678, 1'b1, 1'b0);
        in1 = x;
        for (int e = 0; e < 3; e++) begin
            #1;
            total++; if (st1 !== (e < 2)) $display("FAIL w2_store_stall%0d got %b exp %b", e, st1, e < 2); else passed++;
            @(negedge clk); #1;
            total++; if (ram(1, 2) !== (e == 2 ? 32'h1234_5678 : 32'hA5A5_0001)) $display("FAIL w2_store_ram%0d got %h", e, ram(1, 2)); else passed++;
        end
        total++; if (obs1 !== expv(x, 32'h0, 1'b0)) $display("FAIL w2_store_out got %h exp %h", obs1, expv(x, 32'h0, 1'b0)); else passed++;
        mdl[1][2] = 32'h1234_5678; kn[1][2] = 1'b1;
        in1 = '0;
    endtask

    task automatic test_wait_load;
        in_t x;
        x = mk(32'h1001_0008, $urandom, 1'b0, 1'b1);
        x.rw = 1'b1;
        in1 = x;
        for (int e = 0; e < 3; e++) begin
            #1;
            total++; if (st1 !== (e < 2)) $display("FAIL w2_load_stall%0d got %b exp %b", e, st1, e < 2); else passed++;
            @(negedge clk); #1;
            if (e < 2) begin
                total++; if (obs1 !== '0) $display("FAIL w2_load_bubble%0d got %h exp 0", e, obs1); else passed++;
            end
        end
        total++; if (obs1 !== expv(x, 32'h1234_5678, 1'b0)) $display("FAIL w2_load_out got %h exp %h", obs1, expv(x, 32'h1234_5678, 1'b0)); else passed++;
        in1 = '0;
    endtask

    task automatic test_reset_mid;
        in1 = mk(32'h1001_0008, 32'hCAFE_F00D, 1'b1, 1'b0);
        #1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk); #1;
        total++; if (obs1 !== '0) $display("FAIL rst_mid_out got %h exp 0", obs1); else passed++;
        total++; if (ram(1, 2) !== mdl[1][2]) $display("FAIL rst_mid_ram got %h exp %h", ram(1, 2), mdl[1][2]); else passed++;
        rst = 1'b0;
        in1 = '0;
        #1;
        total++; if (st1 !== 1'b0) $display("FAIL rst_mid_stall got %b exp 0", st1); else passed++;
    endtask

    task automatic test_alias;
        in_t x;
        x = mk(BASE + 32'd1024, 32'h0BAD_CAFE, 1'b1, 1'b0);
        in0 = x;
        @(negedge clk); #1;
        total++; if (ram(0, 0) !== 32'h0BAD_CAFE) $display("FAIL alias_ram got %h exp 0badcafe", ram(0, 0)); else passed++;
        mdl[0][0] = 32'h0BAD_CAFE; kn[0][0] = 1'b1;
        x = mk(BASE, $urandom, 1'b0, 1'b1);
        in0 = x;
        @(negedge clk); #1;
        total++; if (obs0 !== expv(x, 32'h0BAD_CAFE, 1'b0)) $display("FAIL alias_load got %h exp %h", obs0, expv(x, 32'h0BAD_CAFE, 1'b0)); else passed++;
        in0 = '0;
        x = mk($urandom, $urandom, 1'b0, 1'b0);
        in1 = x;
        #1;
        total++; if (st1 !== 1'b0) $display("FAIL alu_stall got %b exp 0", st1); else passed++;
        @(negedge clk); #1;
        total++; if (obs1 !== expv(x, 32'h0, 1'b0)) $display("FAIL alu_pass got %h exp %h", obs1, expv(x, 32'h0, 1'b0)); else passed++;
        in1 = '0;
    endtask

    task automatic test_misalign;
        in_t x;
        logic [31:0] old;
        old = mdl[0][0];
        x = mk(32'h1001_0002, 32'h5555_AAAA, 1'b1, 1'b0);
        x.rw = 1'b1;
        in0 = x;
        @(negedge clk); #1;
`ifdef MEM_ALIGN_CHECK_EN
        total++; if (obs0 !== expv(x, 32'h0, 1'b1)) $display("FAIL misalign_out got %h exp %h", obs0, expv(x, 32'h0, 1'b1)); else passed++;
        total++; if (ram(0, 0) !== old) $display("FAIL misalign_ram got %h exp %h", ram(0, 0), old); else passed++;
`else
        total++; if (obs0 !== expv(x, 32'h0, 1'b0)) $display("FAIL misalign_off_out got %h exp %h", obs0, expv(x, 32'h0, 1'b0)); else passed++;
        total++; if (ram(0, 0) !== 32'h5555_AAAA) $display("FAIL misalign_off_ram got %h exp 5555aaaa was %h", ram(0, 0), old); else passed++;
        mdl[0][0] = 32'h5555_AAAA;
`endif
        in0 = '0;
    endtask

    task automatic test_random(input int w);
        in_t x;
        logic [31:0] a, old;
        bit okn;
        int k, id, n;
        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(0, 2);
            a = BASE + 32'($urandom_range(0, 1023)) * 4;
            id = idx(a);
            if (k == 2 && !kn[w][id]) k = 1;
            x = mk(k == 0 ? 32'($urandom) : a, $urandom, k == 1, k == 2);
            n = (w != 0 && k != 0) ? 3 : 1;
            old = mdl[w][id];
            okn = kn[w][id];
            if (w != 0) in1 = x; else in0 = x;
            for (int e = 0; e < n; e++) begin
                #1;
                total++; if ((w != 0 ? st1 : st0) !== (e < n - 1)) $display("FAIL rnd%0d_stall t%0d e%0d got %b", w, t, e, w != 0 ? st1 : st0); else passed++;
                @(negedge clk); #1;
                total++;
                if ((w != 0 ? obs1 : obs0) !== (e < n - 1 ? '0 : expv(x, k == 2 ? old : 32'h0, 1'b0)))
                    $display("FAIL rnd%0d_out t%0d e%0d got %h", w, t, e, w != 0 ? obs1 : obs0);
                else passed++;
                if (k == 1 && (okn || e == n - 1)) begin
                    total++; if (ram(w, id) !== (e == n - 1 ? x.wd : old)) $display("FAIL rnd%0d_ram t%0d e%0d got %h", w, t, e, ram(w, id)); else passed++;
                end
            end
            if (k == 1) begin
                mdl[w][id] = x.wd;
                kn[w][id] = 1'b1;
            end
        end
        if (w != 0) in1 = '0; else in0 = '0;
    endtask

    initial begin
        test_reset;
        test_wait0;
        test_wait_store;
        test_wait_load;
        test_reset_mid;
        test_alias;
        test_misalign;
        test_random(0);
        test_random(1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout after 200000 time units");
        $fatal(1);
    end
endmodule
